wired_lsu_arb: RTL

Two-requester arbiter in front of the single LSU request/response port. It shares the port between the speculative LSU issue queue (port 0) and the non-flushable committed-store/cache-maintenance path (port 1). It keeps an in-order tracking queue of outstanding requests so that each in-order LSU response is routed back to its originator. Responses for port-0 requests killed by a pipeline flush are silently dropped.

---
 rtl/wired_lsu_arb_pkg.sv | 27 ++
 rtl/wired_lsu_arb_track.sv | 74 +++++++
 rtl/wired_lsu_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wired_lsu_arb_pkg.sv
// Shared LSU request/response types plus the arbiter's tracking-entry types.
package wired_lsu_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  op;
    } iq_lsu_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } iq_lsu_resp_t;

    // Originator of a request: speculative IQ (flushable) or committed path.
    typedef enum logic {
        SRC_IQ  = 1'b0,
        SRC_CMT = 1'b1
    } lsu_src_t;

    typedef struct packed {
        lsu_src_t src;
        logic     killed;
    } lsu_trk_t;

endpackage

// File: rtl/wired_lsu_arb_track.sv
// In-order tracking queue of outstanding LSU requests (source + killed flag).
module wired_lsu_arb_track
    import wired_lsu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  lsu_trk_t                 push_data_i,
    input  logic                     pop_i,
    input  logic                     kill_src0_i,
    output lsu_trk_t                 head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    lsu_trk_t          ent_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     off [DEPTH];
    logic [DEPTH-1:0]  live_mask;

    // Mark which slots currently hold outstanding entries (distance from head < count).
    always_comb begin
        live_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off[i]       = AW'(i) - rptr_q;
            live_mask[i] = ({1'b0, off[i]} < cnt_q);
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Entry storage: flush marks live IQ entries killed; a same-cycle push carries its own flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_src0_i && live_mask[i] && ent_q[i].src == SRC_IQ)
                    ent_q[i].killed <= 1'b1;
            end
            if (push_i) ent_q[wptr_q] <= push_data_i;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = ent_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/wired_lsu_arb.sv
// Two-port arbiter sharing the LSU request port; routes in-order responses back.
module wired_lsu_arb
    import wired_lsu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    req0_valid_i,
    output logic                    req0_ready_o,
    input  iq_lsu_req_t             req0_i,
    input  logic                    req1_valid_i,
    output logic                    req1_ready_o,
    input  iq_lsu_req_t             req1_i,
    output logic                    lsu_req_valid_o,
    input  logic                    lsu_req_ready_i,
    output iq_lsu_req_t             lsu_req_o,
    input  logic                    lsu_resp_valid_i,
    output logic                    lsu_resp_ready_o,
    input  iq_lsu_resp_t            lsu_resp_i,
    output logic                    resp0_valid_o,
    input  logic                    resp0_ready_i,
    output logic                    resp1_valid_o,
    input  logic                    resp1_ready_i,
    output iq_lsu_resp_t            resp0_o,
    output iq_lsu_resp_t            resp1_o,
    output logic [$clog2(DEPTH):0]  outstanding_o,
    output logic                    idle_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          out_valid_q, out_valid_d;
    iq_lsu_req_t   out_req_q, out_req_d;
    lsu_src_t      out_src_q, out_src_d;
    lsu_src_t      last_q, last_d;

    logic          load, room, gnt0, gnt1, hs, pop;
    logic [CW-1:0] cnt;
    logic          trk_empty;
    lsu_trk_t      trk_head, trk_push;

    assign load     = !out_valid_q || lsu_req_ready_i;
    assign room     = (cnt + CW'(out_valid_q)) < CW'(DEPTH);
    assign hs       = out_valid_q && lsu_req_ready_i;
    assign trk_push = '{src: out_src_q, killed: flush_i && (out_src_q == SRC_IQ)};

    // Grant: flush blocks port 0; a tie goes to the port that did not win last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (load && room) begin
            if (req0_valid_i && !flush_i && req1_valid_i) begin
                if (last_q == SRC_CMT) gnt0 = 1'b1;
                else                   gnt1 = 1'b1;
            end else if (req0_valid_i && !flush_i) begin
                gnt0 = 1'b1;
            end else if (req1_valid_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Stage next-state; without load the stage holds unless a flush kills a staged IQ request.
    always_comb begin
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = gnt0 || gnt1;
            if (gnt0) begin
                out_req_d = req0_i;
                out_src_d = SRC_IQ;
                last_d    = SRC_IQ;
            end else if (gnt1) begin
                out_req_d = req1_i;
                out_src_d = SRC_CMT;
                last_d    = SRC_CMT;
            end
        end else if (flush_i && out_src_q == SRC_IQ) begin
            out_valid_d = 1'b0;
        end
    end

    // Stage register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
            out_src_q   <= SRC_IQ;
            last_q      <= SRC_CMT;
        end else begin
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    // Response routing from the queue head; killed heads and an empty queue swallow responses.
    always_comb begin
        resp0_valid_o    = 1'b0;
        resp1_valid_o    = 1'b0;
        lsu_resp_ready_o = 1'b1;
        pop              = 1'b0;
        if (!trk_empty) begin
            if (trk_head.killed) begin
                pop = lsu_resp_valid_i;
            end else if (trk_head.src == SRC_IQ) begin
                resp0_valid_o    = lsu_resp_valid_i;
                lsu_resp_ready_o = resp0_ready_i;
                pop              = lsu_resp_valid_i && resp0_ready_i;
            end else begin
                resp1_valid_o    = lsu_resp_valid_i;
                lsu_resp_ready_o = resp1_ready_i;
                pop              = lsu_resp_valid_i && resp1_ready_i;
            end
        end
    end

    wired_lsu_arb_track #(
        .DEPTH (DEPTH)
    ) u_track (
        .clk         (clk),
        .rst         (rst),
        .push_i      (hs),
        .push_data_i (trk_push),
        .pop_i       (pop),
        .kill_src0_i (flush_i),
        .head_o      (trk_head),
        .empty_o     (trk_empty),
        .cnt_o       (cnt)
    );

    assign req0_ready_o    = gnt0;
    assign req1_ready_o    = gnt1;
    assign lsu_req_valid_o = out_valid_q;
    assign lsu_req_o       = out_req_q;
    assign resp0_o         = lsu_resp_i;
    assign resp1_o         = lsu_resp_i;
    assign outstanding_o   = cnt;
    assign idle_o          = !out_valid_q && trk_empty;

endmodule
